// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register target.
package spi_reg_pkg;

    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned CMD_READ_BIT = 7;
    localparam int unsigned BIT_CNT_W    = 3;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA  = 2'd2,
        ABORT = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_reg_target_pin_sync.sv
// Multi-stage input synchronizer with registered level and rise/fall strobes.
// The level output is aligned with the strobes: when rise is high, level is 1.
module pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;

    // Synchronizer chain followed by one edge-detect stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            level <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            level <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~level;
            fall  <= ~chain[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target exposing a small bank of 8-bit control registers plus a
// read-only status byte at address 0x7F.
// Build option: define SPI_AUTOINC_EN to step the address after every data
// byte (modulo 128); otherwise the address stays fixed for the transaction.
module spi_reg_target
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [7:0]            status_i,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic [NUM_REGS-1:0]   wr_pulse_o
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_state_t state, state_nxt;

    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           rx_shift;
    logic [7:0]           tx_shift;
    logic [ADDR_W-1:0]    addr;
    logic                 is_read;
    logic                 tx_hold;

    logic                 active_c;
    logic                 bit_c;
    logic                 cmd_done_c;
    logic                 data_done_c;
    logic [7:0]           rx_byte_c;
    logic [ADDR_W-1:0]    addr_nxt_c;
    logic [ADDR_W-1:0]    rd_addr_c;
    logic [7:0]           rd_data_c;
    logic                 load_c;
    logic                 shift_out_c;
    logic [NUM_REGS-1:0]  wr_sel_c;

    logic unused_pins;
    assign unused_pins = sclk_lvl ^ cs_rise ^ mosi_rise ^ mosi_fall;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: chip select high in any active state aborts the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cs_fall && ena) state_nxt = CMD;
            end
            CMD: begin
                if (cs_lvl)                                  state_nxt = ABORT;
                else if (sclk_rise && (bit_cnt == LAST_BIT)) state_nxt = DATA;
            end
            DATA: begin
                if (cs_lvl) state_nxt = ABORT;
            end
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: byte-boundary strobes, read source select and write decode.
    always_comb begin
        active_c    = ((state == CMD) || (state == DATA)) && !cs_lvl;
        bit_c       = active_c && sclk_rise;
        cmd_done_c  = bit_c && (bit_cnt == LAST_BIT) && (state == CMD);
        data_done_c = bit_c && (bit_cnt == LAST_BIT) && (state == DATA);
        rx_byte_c   = {rx_shift[6:0], mosi_lvl};
`ifdef SPI_AUTOINC_EN
        addr_nxt_c  = addr + ADDR_W'(1);
`else
        addr_nxt_c  = addr;
`endif
        rd_addr_c   = cmd_done_c ? rx_byte_c[ADDR_W-1:0] : addr_nxt_c;
        rd_data_c   = 8'h00;
        if (rd_addr_c == STATUS_ADDR) rd_data_c = status_i;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            if (rd_addr_c == ADDR_W'(n)) rd_data_c = regs_o[n*8 +: 8];
        end
        load_c      = (cmd_done_c && rx_byte_c[CMD_READ_BIT]) || (data_done_c && is_read);
        shift_out_c = active_c && miso_oe && sclk_fall;
        wr_sel_c    = '0;
        for (int unsigned n = 0; n < NUM_REGS; n++) begin
            wr_sel_c[n] = data_done_c && !is_read && (addr == ADDR_W'(n));
        end
    end

    // Datapath: bit shifting, register commit and miso serialization.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            addr       <= '0;
            is_read    <= 1'b0;
            tx_hold    <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            regs_o     <= '0;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= wr_sel_c;
            for (int unsigned n = 0; n < NUM_REGS; n++) begin
                if (wr_sel_c[n]) regs_o[n*8 +: 8] <= rx_byte_c;
            end
            if ((state == IDLE) || (state == ABORT)) begin
                bit_cnt <= '0;
                tx_hold <= 1'b0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                if (bit_c) begin
                    rx_shift <= rx_byte_c;
                    bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                end
                if (cmd_done_c) begin
                    is_read <= rx_byte_c[CMD_READ_BIT];
                    addr    <= rx_byte_c[ADDR_W-1:0];
                end
                if (data_done_c) addr <= addr_nxt_c;
                // A fresh byte presents its MSB at once; the falling edge that
                // closes the current bit must not shift it away.
                if (load_c) begin
                    tx_shift <= rd_data_c;
                    miso     <= rd_data_c[7];
                    miso_oe  <= 1'b1;
                    tx_hold  <= 1'b1;
                end else if (shift_out_c) begin
                    if (tx_hold) begin
                        tx_hold <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso     <= tx_shift[6];
                    end
                end
            end
        end
    end

endmodule
